lpe_result_collector: RTL and testbench

- Terminates the bottom of one PE column in the linear processing array.
- Consumes the column's down-stream AXI Stream, which carries result beats exported by each PE in j order and operand beats leaking past the last PE.
- Discards the operand beats and repackages the PE_NUMBER_J results of each output vector into one framed AXI Stream packet with tlast, tdest and tid for the output interconnect.
- Detects framing and flag errors and resynchronises on the next input tlast.

---
 rtl/lpe_pkg.sv | 33 +++
 rtl/axis_skid_buffer.sv | 54 +++++
 rtl/lpe_result_collector.sv | 117 +++++++++++
 tb/tb_lpe_result_collector.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lpe_pkg.sv
// Shared definitions for the linear processing array edge blocks:
// beat classification, default tuser flag masks and collector states.
package lpe_pkg;

  typedef enum logic [1:0] {
    BEAT_NONE = 2'd0,
    BEAT_OP   = 2'd1,
    BEAT_RSLT = 2'd2,
    BEAT_BAD  = 2'd3
  } beat_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FLUSH   = 1'b1
  } collector_state_t;

  // Flag positions for the default 8-bit column tuser.
  localparam logic [7:0] DEFAULT_OP1_USER_MASK  = 8'h40;
  localparam logic [7:0] DEFAULT_RSLT_USER_MASK = 8'h80;

  // Beat type from the two tuser flag hits; both set is a malformed beat.
  function automatic beat_t classify_beat(input logic op1_hit, input logic rslt_hit);
    beat_t b;
    case ({op1_hit, rslt_hit})
      2'b10:   b = BEAT_OP;
      2'b01:   b = BEAT_RSLT;
      2'b11:   b = BEAT_BAD;
      default: b = BEAT_NONE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI Stream register slice: one cycle latency, full throughput,
// registered ready on the upstream side. Ready is low while in reset.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             main_v;
  logic             skid_v;
  logic             rdy_q;
  logic             s_fire;

  assign s_fire  = s_valid && rdy_q;
  assign s_ready = rdy_q;
  assign m_data  = main_q;
  assign m_valid = main_v;

  // Main register feeds the output; skid register catches the one beat
  // accepted in the cycle the output stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
    end else if (!main_v || m_ready) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= s_fire;
        if (s_fire) main_q <= s_data;
      end
      rdy_q <= 1'b1;
    end else if (s_fire) begin
      skid_q <= s_data;
      skid_v <= 1'b1;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= !skid_v;
    end
  end

endmodule

// File: rtl/lpe_result_collector.sv
// Bottom-of-column terminator: drops operand leakage, frames the
// PE_NUMBER_J results of each vector into one output packet and flags
// framing/flag errors, resynchronising on the next input tlast.
module lpe_result_collector
  import lpe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned PE_NUMBER_J = 4,
  parameter int unsigned USER_WIDTH  = 8,
  parameter logic [USER_WIDTH-1:0] OP1_USER_MASK  = USER_WIDTH'(1) << (USER_WIDTH-2),
  parameter logic [USER_WIDTH-1:0] RSLT_USER_MASK = USER_WIDTH'(1) << (USER_WIDTH-1),
  parameter int unsigned DEST_WIDTH  = 8,
  parameter int unsigned ID_WIDTH    = 8,
  parameter logic [DEST_WIDTH-1:0] OUTPUT_DEST = DEST_WIDTH'(1),
  parameter logic [ID_WIDTH-1:0]   OUTPUT_ID   = ID_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [15:0]           vec_count,
  output logic                  err_count_mismatch,
  output logic                  err_missing_last,
  output logic                  err_user_flag
);

  localparam int unsigned IDX_W = (PE_NUMBER_J > 1) ? $clog2(PE_NUMBER_J) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PE_NUMBER_J - 1);

  collector_state_t state;
  logic [IDX_W-1:0] idx;
  logic             run_q;
  beat_t            beat;
  logic             fwd_cand;
  logic             accept;
  logic             skid_ready;
  logic             skid_valid;
  logic             out_last;

  assign beat     = classify_beat(|(s_axis_tuser & OP1_USER_MASK),
                                  |(s_axis_tuser & RSLT_USER_MASK));
  assign fwd_cand = (state == ST_COLLECT) && (beat == BEAT_RSLT);

  // Only forwarded results see output back-pressure; everything else is
  // swallowed as soon as the block is out of reset.
  assign s_axis_tready = run_q && (fwd_cand ? skid_ready : 1'b1);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign skid_valid    = s_axis_tvalid && run_q && fwd_cand;
  assign out_last      = s_axis_tlast || (idx == LAST_IDX);

  assign m_axis_tdest = OUTPUT_DEST;
  assign m_axis_tid   = OUTPUT_ID;

  axis_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  ({out_last, s_axis_tdata}),
    .s_valid (skid_valid),
    .s_ready (skid_ready),
    .m_data  ({m_axis_tlast, m_axis_tdata}),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  // Framing state machine: result index, packet count and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_COLLECT;
      idx                <= '0;
      vec_count          <= '0;
      run_q              <= 1'b0;
      err_count_mismatch <= 1'b0;
      err_missing_last   <= 1'b0;
      err_user_flag      <= 1'b0;
    end else begin
      run_q              <= 1'b1;
      err_count_mismatch <= 1'b0;
      err_missing_last   <= 1'b0;
      err_user_flag      <= 1'b0;
      if (accept) begin
        if (beat == BEAT_BAD) begin
          err_user_flag <= 1'b1;
        end else if (beat == BEAT_RSLT) begin
          if (state == ST_FLUSH) begin
            if (s_axis_tlast) state <= ST_COLLECT;
            idx <= '0;
          end else if (idx == LAST_IDX) begin
            idx <= '0;
            if (s_axis_tlast) begin
              vec_count <= vec_count + 16'd1;
            end else begin
              err_missing_last <= 1'b1;
              state            <= ST_FLUSH;
            end
          end else if (s_axis_tlast) begin
            err_count_mismatch <= 1'b1;
            idx                <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lpe_result_collector.sv
// Directed bench for lpe_result_collector with PE_NUMBER_J=4.
module tb_lpe_result_collector;

  localparam logic [7:0] U_OP   = 8'h40;
  localparam logic [7:0] U_RSLT = 8'h80;
  localparam logic [7:0] U_BAD  = 8'hC0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  s_axis_tuser = U_RSLT;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tdest;
  logic [7:0]  m_axis_tid;
  logic [15:0] vec_count;
  logic        err_count_mismatch;
  logic        err_missing_last;
  logic        err_user_flag;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_mis = 0, n_miss = 0, n_user = 0;
  logic [16:0] out_q[$];
  logic [16:0] exp_q[$];
  int unsigned w;

  lpe_result_collector #(
    .DATA_WIDTH(16), .PE_NUMBER_J(4), .USER_WIDTH(8),
    .DEST_WIDTH(8), .ID_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdest(m_axis_tdest), .m_axis_tid(m_axis_tid),
    .vec_count(vec_count),
    .err_count_mismatch(err_count_mismatch),
    .err_missing_last(err_missing_last),
    .err_user_flag(err_user_flag)
  );

  always #5 clk = ~clk;

  // Record output handshakes and error pulses mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
      if (err_count_mismatch) n_mis++;
      if (err_missing_last) n_miss++;
      if (err_user_flag) n_user++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one beat and hold it until accepted; reports cycles waited.
  task automatic send(input logic [15:0] d, input logic [7:0] u, input logic l,
                      output int unsigned waited);
    logic done;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    waited = 0;
    done   = 1'b0;
    while (!done && waited < 64) begin
      @(negedge clk);
      if (s_axis_tready) done = 1'b1;
      else waited++;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] base);
    for (int unsigned i = 0; i < 4; i++) send(base + 16'(i), U_RSLT, i == 3, w);
  endtask

  task automatic push_vec(input logic [15:0] base);
    for (int unsigned i = 0; i < 4; i++) exp_q.push_back({i == 3, base + 16'(i)});
  endtask

  task automatic compare_out(input string tag);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_len"}, out_q.size(), exp_q.size());
    for (int unsigned i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic check_errs(input string tag, input int unsigned mis,
                            input int unsigned miss, input int unsigned usr);
    check({tag, "_err_mismatch"}, n_mis, mis);
    check({tag, "_err_missing"}, n_miss, miss);
    check({tag, "_err_user"}, n_user, usr);
    n_mis = 0; n_miss = 0; n_user = 0;
  endtask

  initial begin
    // Reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_vec_count", vec_count, 16'd0);
    @(posedge clk); #1;
    check("post_rst_tready", s_axis_tready, 1'b1);
    check("tdest", m_axis_tdest, 8'd1);
    check("tid", m_axis_tid, 8'd1);

    // Clean vector, first-beat latency of one cycle
    check("pre_tvalid", m_axis_tvalid, 1'b0);
    send(16'h0011, U_RSLT, 1'b0, w);
    check("lat_tvalid", m_axis_tvalid, 1'b1);
    check("lat_tdata", m_axis_tdata, 16'h0011);
    for (int unsigned i = 1; i < 4; i++) send(16'h0011 + 16'(i), U_RSLT, i == 3, w);
    push_vec(16'h0011);
    compare_out("clean");
    check("clean_vec_count", vec_count, 16'd1);
    check_errs("clean", 0, 0, 0);

    // OP beats interleaved during a 5-cycle output stall
    fork
      begin
        m_axis_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_axis_tready = 1'b1;
      end
    join_none
    send(16'h0011, U_RSLT, 1'b0, w);
    send(16'h0012, U_RSLT, 1'b0, w);
    send(16'hFFFF, U_OP, 1'b0, w);
    check("op_no_wait0", w, 0);
    send(16'hFFFE, U_OP, 1'b1, w);
    check("op_no_wait1", w, 0);
    send(16'h0013, U_RSLT, 1'b0, w);
    send(16'hFFFD, U_OP, 1'b0, w);
    send(16'h0014, U_RSLT, 1'b1, w);
    push_vec(16'h0011);
    compare_out("stall");
    check("stall_vec_count", vec_count, 16'd2);
    check_errs("stall", 0, 0, 0);

    // Truncated packet
    send(16'h00A1, U_RSLT, 1'b0, w);
    send(16'h00A2, U_RSLT, 1'b1, w);
    exp_q.push_back({1'b0, 16'h00A1});
    exp_q.push_back({1'b1, 16'h00A2});
    compare_out("trunc");
    check("trunc_vec_count", vec_count, 16'd2);
    check_errs("trunc", 1, 0, 0);
    send_vec(16'h0061);
    push_vec(16'h0061);
    compare_out("after_trunc");
    check("after_trunc_vec_count", vec_count, 16'd3);

    // Missing tlast: forced end, then flush until the next input tlast
    send_vec(16'h00B1);
    for (int unsigned i = 0; i < 4; i++) send(16'h00B1 + 16'(i), U_RSLT, 1'b0, w);
    send(16'h00B5, U_RSLT, 1'b0, w);
    send(16'h00B6, U_RSLT, 1'b1, w);
    send_vec(16'h0021);
    // First vector above is a clean one; then B1..B4 with forced last.
    push_vec(16'h00B1);
    push_vec(16'h00B1);
    push_vec(16'h0021);
    compare_out("missing");
    check("missing_vec_count", vec_count, 16'd5);
    check_errs("missing", 0, 1, 0);

    // Both flags set mid-vector
    send(16'h0031, U_RSLT, 1'b0, w);
    send(16'h0032, U_RSLT, 1'b0, w);
    send(16'hDEAD, U_BAD, 1'b1, w);
    send(16'h0033, U_RSLT, 1'b0, w);
    send(16'h0034, U_RSLT, 1'b1, w);
    push_vec(16'h0031);
    compare_out("bad");
    check("bad_vec_count", vec_count, 16'd6);
    check_errs("bad", 0, 0, 1);

    // Reset with a partial packet held in the skid buffer
    m_axis_tready = 1'b0;
    send(16'h0041, U_RSLT, 1'b0, w);
    send(16'h0042, U_RSLT, 1'b0, w);
    rst = 1'b1;
    s_axis_tuser = U_RSLT;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_vec_count", vec_count, 16'd0);
    m_axis_tready = 1'b1;
    out_q.delete();
    send_vec(16'h0051);
    push_vec(16'h0051);
    compare_out("midrst");
    check("midrst_vec_after", vec_count, 16'd1);
    check_errs("midrst", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
